// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory interface.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SzByte  = 2'b00,
    SzHalf  = 2'b01,
    SzWord  = 2'b10,
    SzDword = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDrain
  } state_e;

  // Byte-enable mask for an access of the given size at the given byte offset.
  function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SzByte:  base = 8'h01;
      SzHalf:  base = 8'h03;
      SzWord:  base = 8'h0f;
      default: base = 8'hff;
    endcase
    return base << offset;
  endfunction

  function automatic logic align_ok(input logic [1:0] size, input logic [2:0] addr);
    case (size)
      SzByte:  return 1'b1;
      SzHalf:  return ~addr[0];
      SzWord:  return addr[1:0] == 2'b00;
      default: return addr == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it to DATA_W.
module mem_load_align
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]           rdata,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic [1:0]                  size,
  input  logic                        sext,
  output logic [DATA_W-1:0]           data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    unique case (size)
      SzByte: begin
        mask = DATA_W'(8'hff);
        sign = shifted[7];
      end
      SzHalf: begin
        mask = DATA_W'(16'hffff);
        sign = shifted[15];
      end
      SzWord: begin
        mask = DATA_W'(32'hffff_ffff);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = shifted[DATA_W-1];
      end
    endcase
    data = (shifted & mask) | ({DATA_W{sext & sign}} & ~mask);
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one req/addr_ok/data_ok transaction per load/store, with stall,
// misalignment exceptions, flush/drain handling and load/store lane formatting.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SIZE_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic                in_mem_en,
  input  logic                in_mem_wr,
  input  logic [SIZE_W-1:0]   in_size,
  input  logic                in_sext,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [SIZE_W-1:0]   size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                stall,
  output logic                out_valid,
  output logic [DATA_W-1:0]   result,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [ADDR_W-1:0]   badvaddr
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(StrbW);

  state_e              state_q, state_d;
  logic                wr_q, sext_q;
  logic [SIZE_W-1:0]   size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [StrbW-1:0]    wstrb_q, strb_in;
  logic [DATA_W-1:0]   wdata_q, wdata_in, load_data;
  logic                mem_op, non_mem, misaligned, go, issue, done;

  assign mem_op     = in_valid & in_mem_en;
  assign non_mem    = in_valid & ~in_mem_en;
  assign misaligned = mem_op & (~align_ok(in_size[1:0], in_addr[2:0]) |
                                (DATA_W == 32 && in_size[1:0] == SzDword));
  assign go         = resetn & mem_op & ~misaligned & ~flush;

  assign strb_in = StrbW'(strb_gen(in_size[1:0], 3'(in_addr[LaneW-1:0])));

  always_comb begin
    unique case (in_size[1:0])
      SzByte:  wdata_in = {StrbW{in_wdata[7:0]}};
      SzHalf:  wdata_in = {(DATA_W/16){in_wdata[15:0]}};
      SzWord:  wdata_in = {(DATA_W/32){in_wdata[31:0]}};
      default: wdata_in = in_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          req     = 1'b1;
          issue   = 1'b1;
          state_d = addr_ok ? StResp : StReq;
        end
      end
      StReq: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          req = 1'b1;
          if (addr_ok) state_d = StResp;
        end
      end
      StResp: begin
        if (data_ok) begin
          state_d = StIdle;
          done    = ~flush;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The flushed access still owes a response; swallow it before issuing again.
        if (data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        wr_q    <= in_mem_wr;
        sext_q  <= in_sext;
        size_q  <= in_size;
        addr_q  <= in_addr;
        wstrb_q <= strb_in;
        wdata_q <= wdata_in;
      end
    end
  end

  // Issue cycle is zero-bubble from the inputs; afterwards the captured copy is held.
  assign wr    = (state_q == StIdle) ? in_mem_wr : wr_q;
  assign size  = (state_q == StIdle) ? in_size   : size_q;
  assign addr  = (state_q == StIdle) ? in_addr   : addr_q;
  assign wstrb = (state_q == StIdle) ? strb_in   : wstrb_q;
  assign wdata = (state_q == StIdle) ? wdata_in  : wdata_q;

  mem_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .rdata (rdata),
    .offset(addr_q[LaneW-1:0]),
    .size  (size_q[1:0]),
    .sext  (sext_q),
    .data  (load_data)
  );

  assign stall = resetn & ~flush &
                 ((go & ~(state_q == StResp & data_ok)) | (state_q == StDrain & mem_op));

  assign out_valid = resetn & ~flush & ~stall & (non_mem | misaligned | done);
  assign exc_adel  = out_valid & misaligned & ~in_mem_wr;
  assign exc_ades  = out_valid & misaligned & in_mem_wr;
  assign badvaddr  = (exc_adel | exc_ades) ? in_addr : '0;

  always_comb begin
    result = '0;
    if (out_valid) begin
      if (non_mem)             result = in_alu;
      else if (done && !wr_q)  result = load_data;
    end
  end

  a_no_ok_collision: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == StIdle && go) |-> !(addr_ok && data_ok));

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: 32-bit instance plus a 64-bit instance for dword paths.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_mem_en, in_mem_wr, in_sext, flush, addr_ok, data_ok;
  logic [1:0]  in_size, size;
  logic [31:0] in_addr, in_wdata, in_alu, addr, wdata, rdata, result, badvaddr;
  logic [3:0]  wstrb;
  logic        req, wr, stall, out_valid, exc_adel, exc_ades;

  logic        e_in_valid, e_in_mem_en;
  logic [63:0] e_in_wdata, e_in_alu, e_wdata, e_rdata, e_result;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_badvaddr;
  logic [7:0]  e_wstrb;
  logic        e_req, e_wr, e_stall, e_out_valid, e_exc_adel, e_exc_ades;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_mem_en(in_mem_en),
    .in_mem_wr(in_mem_wr), .in_size(in_size), .in_sext(in_sext), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_alu(in_alu), .flush(flush), .req(req), .wr(wr), .size(size),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .stall(stall), .out_valid(out_valid), .result(result),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
  );

  mem_access_stage #(.DATA_W(64)) u_dut64 (
    .clk(clk), .resetn(resetn), .in_valid(e_in_valid), .in_mem_en(e_in_mem_en),
    .in_mem_wr(in_mem_wr), .in_size(in_size), .in_sext(in_sext), .in_addr(in_addr),
    .in_wdata(e_in_wdata), .in_alu(e_in_alu), .flush(flush), .req(e_req), .wr(e_wr),
    .size(e_size), .addr(e_addr), .wstrb(e_wstrb), .wdata(e_wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(e_rdata), .stall(e_stall), .out_valid(e_out_valid),
    .result(e_result), .exc_adel(e_exc_adel), .exc_ades(e_exc_ades), .badvaddr(e_badvaddr)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_mem_en = 0; in_mem_wr = 0; in_sext = 0; flush = 0;
    addr_ok = 0; data_ok = 0; in_size = 2'b00; in_addr = '0; in_wdata = '0;
    in_alu = '0; rdata = '0;
    e_in_valid = 0; e_in_mem_en = 0; e_in_wdata = '0; e_in_alu = '0; e_rdata = '0;
  endtask

  task automatic mem_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] src);
    in_valid = 1; in_mem_en = 1; in_mem_wr = w; in_size = sz; in_sext = sx;
    in_addr = a; in_wdata = src;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle();
    mem_op(0, 2'b10, 0, 32'h100, 0);
    addr_ok = 1;
    cyc(); #1;
    checks++;
    if ({req, stall, out_valid, exc_adel, exc_ades} !== 5'b0 || result !== 0 || badvaddr !== 0) begin
      failures++;
      $display("FAIL reset_outputs got req/stall/ov/adel/ades=%b result=%h bad=%h want 0",
               {req, stall, out_valid, exc_adel, exc_ades}, result, badvaddr);
    end
    cyc(); idle(); resetn = 1;
    cyc(); #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got %b want 000", {req, stall, out_valid});
    end
  endtask

  task automatic test_lb_sext();
    cyc(); mem_op(0, 2'b00, 1, 32'h1003, 0); addr_ok = 1; #1;
    checks++;
    if ({req, wr, stall, out_valid} !== 4'b1010 || addr !== 32'h1003 || size !== 2'b00) begin
      failures++;
      $display("FAIL lb_issue got req/wr/stall/ov=%b addr=%h want 1010 addr=1003",
               {req, wr, stall, out_valid}, addr);
    end
    cyc(); addr_ok = 0; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b010) begin
      failures++;
      $display("FAIL lb_wait got req/stall/ov=%b want 010", {req, stall, out_valid});
    end
    cyc(); data_ok = 1; rdata = 32'h80ff_0000; #1;
    checks++;
    if ({stall, out_valid} !== 2'b01 || result !== 32'hffff_ff80) begin
      failures++;
      $display("FAIL lb_done got stall/ov=%b result=%h want 01 ffffff80", {stall, out_valid}, result);
    end
    cyc(); idle(); #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL lb_after got %b want 000", {req, stall, out_valid});
    end
  endtask

  task automatic test_sh_store();
    cyc(); mem_op(1, 2'b01, 0, 32'h2002, 32'h1234_abcd); addr_ok = 1; #1;
    checks++;
    if ({req, wr, stall} !== 3'b111 || wstrb !== 4'b1100 || wdata !== 32'habcd_abcd) begin
      failures++;
      $display("FAIL sh_issue got req/wr/stall=%b strb=%b wdata=%h want 111 1100 abcdabcd",
               {req, wr, stall}, wstrb, wdata);
    end
    cyc(); addr_ok = 0; data_ok = 1; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b001 || result !== 0) begin
      failures++;
      $display("FAIL sh_done got req/stall/ov=%b result=%h want 001 0", {req, stall, out_valid}, result);
    end
    cyc(); idle();
  endtask

  task automatic test_misaligned();
    mem_op(0, 2'b10, 0, 32'h3001, 0); #1;
    checks++;
    if ({req, stall, out_valid, exc_adel, exc_ades} !== 5'b00110 || badvaddr !== 32'h3001 ||
        result !== 0) begin
      failures++;
      $display("FAIL lw_adel got req/stall/ov/adel/ades=%b bad=%h res=%h want 00110 3001 0",
               {req, stall, out_valid, exc_adel, exc_ades}, badvaddr, result);
    end
    cyc(); mem_op(1, 2'b10, 0, 32'h3002, 32'h55); #1;
    checks++;
    if ({req, stall, out_valid, exc_adel, exc_ades} !== 5'b00101 || badvaddr !== 32'h3002) begin
      failures++;
      $display("FAIL sw_ades got %b bad=%h want 00101 3002",
               {req, stall, out_valid, exc_adel, exc_ades}, badvaddr);
    end
    cyc(); mem_op(0, 2'b01, 1, 32'h3001, 0); #1;
    checks++;
    if ({req, exc_adel} !== 2'b01) begin
      failures++;
      $display("FAIL lh_adel got req/adel=%b want 01", {req, exc_adel});
    end
    cyc(); mem_op(0, 2'b11, 0, 32'h8, 0); #1;
    checks++;
    if ({req, exc_adel, badvaddr} !== {2'b01, 32'h8}) begin
      failures++;
      $display("FAIL ld32_adel got req/adel=%b bad=%h want 01 8", {req, exc_adel}, badvaddr);
    end
    cyc(); idle(); in_valid = 1; in_alu = 32'hdead_beef; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b001 || result !== 32'hdead_beef) begin
      failures++;
      $display("FAIL nonmem got req/stall/ov=%b result=%h want 001 deadbeef",
               {req, stall, out_valid}, result);
    end
    cyc(); idle();
  endtask

  task automatic test_addr_delay();
    cyc(); mem_op(0, 2'b10, 0, 32'h4000, 0); #1;
    checks++;
    if ({req, stall} !== 2'b11) begin
      failures++;
      $display("FAIL lw_delay_issue got req/stall=%b want 11", {req, stall});
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      in_addr = (i == 1) ? 32'h4444 : 32'h4000;
      addr_ok = (i == 3);
      #1;
      checks++;
      if ({req, stall, out_valid} !== 3'b110 || addr !== 32'h4000) begin
        failures++;
        $display("FAIL lw_delay_hold%0d got req/stall/ov=%b addr=%h want 110 4000",
                 i, {req, stall, out_valid}, addr);
      end
    end
    cyc(); addr_ok = 0; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b010) begin
      failures++;
      $display("FAIL lw_delay_resp got %b want 010", {req, stall, out_valid});
    end
    cyc(); data_ok = 1; rdata = 32'hcafe_f00d; #1;
    checks++;
    if ({stall, out_valid} !== 2'b01 || result !== 32'hcafe_f00d) begin
      failures++;
      $display("FAIL lw_delay_done got stall/ov=%b result=%h want 01 cafef00d",
               {stall, out_valid}, result);
    end
    cyc(); data_ok = 0; #1;
    checks++;
    if ({req, out_valid} !== 2'b10) begin
      // Inputs still present the op for one more cycle: it must look like a fresh issue.
      failures++;
      $display("FAIL lw_delay_reissue got req/ov=%b want 10", {req, out_valid});
    end
    addr_ok = 1;
    cyc(); addr_ok = 0; data_ok = 1; cyc(); idle();
  endtask

  task automatic test_flush_drain();
    cyc(); mem_op(0, 2'b10, 0, 32'h6000, 0); addr_ok = 1;
    cyc(); addr_ok = 0; flush = 1; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL flush_resp got req/stall/ov=%b want 000", {req, stall, out_valid});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); flush = 0; mem_op(0, 2'b10, 0, 32'h7004, 0);
      data_ok = (i == 2); rdata = 32'h1111_1111; #1;
      checks++;
      if ({req, stall, out_valid} !== 3'b010) begin
        failures++;
        $display("FAIL drain_hold%0d got req/stall/ov=%b want 010", i, {req, stall, out_valid});
      end
    end
    cyc(); data_ok = 0; addr_ok = 1; #1;
    checks++;
    if ({req, stall} !== 2'b11 || addr !== 32'h7004) begin
      failures++;
      $display("FAIL drain_reissue got req/stall=%b addr=%h want 11 7004", {req, stall}, addr);
    end
    cyc(); addr_ok = 0; data_ok = 1; rdata = 32'h2222_3333; #1;
    checks++;
    if ({stall, out_valid} !== 2'b01 || result !== 32'h2222_3333) begin
      failures++;
      $display("FAIL drain_new_done got stall/ov=%b result=%h want 01 22223333",
               {stall, out_valid}, result);
    end
    cyc(); idle();
  endtask

  task automatic test_reset_midflight();
    cyc(); mem_op(0, 2'b10, 0, 32'h9000, 0);
    cyc(); resetn = 0; #1;
    checks++;
    if ({req, stall, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_midflight got req/stall/ov=%b want 000", {req, stall, out_valid});
    end
    cyc(); idle(); resetn = 1;
    cyc(); data_ok = 1; rdata = 32'hffff_ffff; #1;
    checks++;
    if ({req, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL late_data_ok got req/ov=%b want 00", {req, out_valid});
    end
    cyc(); data_ok = 0; mem_op(0, 2'b01, 0, 32'h0002, 0); addr_ok = 1;
    cyc(); addr_ok = 0; data_ok = 1; rdata = 32'h8001_0000; #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0000_8001) begin
      failures++;
      $display("FAIL lhu_done got ov=%b result=%h want 1 00008001", out_valid, result);
    end
    cyc(); idle();
  endtask

  task automatic test_dword64();
    cyc(); idle();
    e_in_valid = 1; e_in_mem_en = 1; in_mem_wr = 0; in_size = 2'b11; in_addr = 32'h8;
    addr_ok = 1; #1;
    checks++;
    if ({e_req, e_stall, e_exc_adel} !== 3'b110 || e_wstrb !== 8'hff) begin
      failures++;
      $display("FAIL ld64_issue got req/stall/adel=%b strb=%h want 110 ff",
               {e_req, e_stall, e_exc_adel}, e_wstrb);
    end
    cyc(); addr_ok = 0; data_ok = 1; e_rdata = 64'h0123_4567_89ab_cdef; #1;
    checks++;
    if ({e_stall, e_out_valid} !== 2'b01 || e_result !== 64'h0123_4567_89ab_cdef) begin
      failures++;
      $display("FAIL ld64_done got stall/ov=%b result=%h want 01 0123456789abcdef",
               {e_stall, e_out_valid}, e_result);
    end
    cyc(); data_ok = 0; in_addr = 32'hc; #1;
    checks++;
    if ({e_req, e_out_valid, e_exc_adel} !== 3'b011 || e_badvaddr !== 32'hc) begin
      failures++;
      $display("FAIL ld64_adel got req/ov/adel=%b bad=%h want 011 c",
               {e_req, e_out_valid, e_exc_adel}, e_badvaddr);
    end
    cyc(); in_mem_wr = 1; in_size = 2'b00; in_addr = 32'h5; e_in_wdata = 64'h77; addr_ok = 1; #1;
    checks++;
    if (e_wstrb !== 8'b0010_0000 || e_wdata !== 64'h7777_7777_7777_7777 || e_wr !== 1'b1) begin
      failures++;
      $display("FAIL sb64_lanes got strb=%b wdata=%h wr=%b want 00100000 7777777777777777 1",
               e_wstrb, e_wdata, e_wr);
    end
    cyc(); addr_ok = 0; data_ok = 1; cyc(); idle();
  endtask

  initial begin
    test_reset();
    test_lb_sext();
    test_sh_store();
    test_misaligned();
    test_addr_delay();
    test_flush_drain();
    test_reset_midflight();
    test_dword64();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
